// File: rtl/ysyx_23060208_ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060208_ifu_fetch_if
// Description : Redirect, AXI4-Lite read and IFU->IDU signals of the fetch stage
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_23060208_ifu_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      redirect_valid;
    logic [DATA_WIDTH-1:0]     redirect_pc;
    logic [DATA_WIDTH-1:0]     araddr;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;
    logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus;
    logic                      ifu_to_idu_valid;
    logic                      idu_allowin;
    logic                      ifu_fault;

    modport master (
        input  redirect_valid, redirect_pc, arready, rdata, rresp, rvalid, idu_allowin,
        output araddr, arvalid, rready, ifu_to_idu_bus, ifu_to_idu_valid, ifu_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, arready, rdata, rresp, rvalid, idu_allowin,
        input  araddr, arvalid, rready, ifu_to_idu_bus, ifu_to_idu_valid, ifu_fault
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060208_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060208_ifu_fetch
// Description : Fetch stage: one AXI4-Lite read per instruction, redirects,
//               wrong-path discard and valid/allowin hand-off to the IDU
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060208_ifu_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
    input  logic                              clock,
    input  logic                              reset,
    ysyx_23060208_ifu_fetch_if.master         fetch
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_HOLD   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_PC_STEP   = DATA_WIDTH'(4);
    localparam logic [1:0]            c_RESP_OKAY = 2'b00;

    state_t                    r_state,   w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_pc,      w_pc_nxt;
    logic                      r_drop,    w_drop_nxt;
    logic                      r_pend,    w_pend_nxt;
    logic [DATA_WIDTH-1:0]     r_pend_pc, w_pend_pc_nxt;
    logic [2*DATA_WIDTH-1:0]   r_bus,     w_bus_nxt;
    logic                      w_ar_fire;

    assign w_ar_fire = (r_state == S_REQ) && fetch.arready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_bus     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_drop    <= w_drop_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_bus     <= w_bus_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drop_nxt    = r_drop;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_bus_nxt     = r_bus;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (fetch.redirect_valid) w_pc_nxt = fetch.redirect_pc;
            end
            S_REQ: begin
                // The address in flight cannot change, so a redirect either
                // waits in pend or turns the issued read into a dropped one.
                if (w_ar_fire) begin
                    w_state_nxt = S_WAIT_R;
                    w_pend_nxt  = 1'b0;
                    if (fetch.redirect_valid) begin
                        w_drop_nxt = 1'b1;
                        w_pc_nxt   = fetch.redirect_pc;
                    end else if (r_pend) begin
                        w_drop_nxt = 1'b1;
                        w_pc_nxt   = r_pend_pc;
                    end
                end else if (fetch.redirect_valid) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = fetch.redirect_pc;
                end
            end
            S_WAIT_R: begin
                if (fetch.rvalid) begin
                    if (fetch.redirect_valid) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = fetch.redirect_pc;
                        w_drop_nxt  = 1'b0;
                    end else if (r_drop) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end else if (fetch.rresp == c_RESP_OKAY) begin
                        w_state_nxt = S_HOLD;
                        w_bus_nxt   = {r_pc, fetch.rdata};
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end else if (fetch.redirect_valid) begin
                    w_drop_nxt = 1'b1;
                    w_pc_nxt   = fetch.redirect_pc;
                end
            end
            S_HOLD: begin
                if (fetch.redirect_valid) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = fetch.redirect_pc;
                end else if (fetch.idu_allowin) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = r_pc + c_PC_STEP;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fetch.araddr           = r_pc;
    assign fetch.arvalid          = (r_state == S_REQ);
    assign fetch.rready           = (r_state == S_WAIT_R);
    assign fetch.ifu_to_idu_bus   = r_bus;
    assign fetch.ifu_to_idu_valid = (r_state == S_HOLD);
    assign fetch.ifu_fault        = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060208_ifu_fetch
// Description : Directed and stall-stream bench for the fetch stage
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060208_ifu_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;

    logic clock;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    ysyx_23060208_ifu_fetch_if #(.DATA_WIDTH(32)) ifc ();

    ysyx_23060208_ifu_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (c_RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fetch (ifc.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    logic [31:0] exp_pc;
    logic [31:0] slv_addr;
    logic [31:0] prev_addr;
    bit          slv_busy;
    bit          prev_stall;
    int          accepted;
    int          cycles;

    initial begin
        reset                 = 1'b1;
        ifc.redirect_valid    = 1'b0;
        ifc.redirect_pc       = '0;
        ifc.arready           = 1'b0;
        ifc.rdata             = '0;
        ifc.rresp             = 2'b00;
        ifc.rvalid            = 1'b0;
        ifc.idu_allowin       = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_arvalid", 64'(ifc.arvalid), 64'd0);
        chk("rst_rready",  64'(ifc.rready), 64'd0);
        chk("rst_valid",   64'(ifc.ifu_to_idu_valid), 64'd0);
        chk("rst_fault",   64'(ifc.ifu_fault), 64'd0);
        chk("rst_bus",     ifc.ifu_to_idu_bus, 64'd0);

        // minimum-latency fetch from RESET_PC
        reset = 1'b0; ifc.arready = 1'b1; ifc.rvalid = 1'b1;
        ifc.rdata = 32'h0000_0013; ifc.idu_allowin = 1'b1;
        @(negedge clock);
        chk("t1_arvalid", 64'(ifc.arvalid), 64'd1);
        chk("t1_araddr",  64'(ifc.araddr), 64'h8000_0000);
        @(negedge clock);
        chk("t1_rready",  64'(ifc.rready), 64'd1);
        @(negedge clock);
        chk("t1_valid",   64'(ifc.ifu_to_idu_valid), 64'd1);
        chk("t1_bus",     ifc.ifu_to_idu_bus, {32'h8000_0000, 32'h0000_0013});
        ifc.rdata = 32'h0010_0093;
        @(negedge clock);
        chk("t1_next_arvalid", 64'(ifc.arvalid), 64'd1);
        chk("t1_next_araddr",  64'(ifc.araddr), 64'h8000_0004);
        ifc.idu_allowin = 1'b0;

        // IDU stall in HOLD
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid",   64'(ifc.ifu_to_idu_valid), 64'd1);
            chk("t2_bus",     ifc.ifu_to_idu_bus, {32'h8000_0004, 32'h0010_0093});
            chk("t2_arvalid", 64'(ifc.arvalid), 64'd0);
            @(negedge clock);
        end
        ifc.idu_allowin = 1'b1;
        @(negedge clock);
        chk("t2_next_araddr", 64'(ifc.araddr), 64'h8000_0008);

        // redirect while the address channel is stalled
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; ifc.arready = 1'b0; ifc.rvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t3_hold1", 64'(ifc.araddr), 64'h8000_0000);
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h8000_0100;
        @(negedge clock);
        ifc.redirect_valid = 1'b0;
        chk("t3_hold2", {31'd0, ifc.arvalid, ifc.araddr}, {31'd0, 1'b1, 32'h8000_0000});
        @(negedge clock);
        chk("t3_hold3", 64'(ifc.araddr), 64'h8000_0000);
        ifc.arready = 1'b1;
        @(negedge clock);
        chk("t3_rready", 64'(ifc.rready), 64'd1);
        ifc.rvalid = 1'b1; ifc.rdata = 32'hDEAD_BEEF; ifc.rresp = 2'b10;
        @(negedge clock);
        chk("t3_drop_valid", 64'(ifc.ifu_to_idu_valid), 64'd0);
        chk("t3_drop_fault", 64'(ifc.ifu_fault), 64'd0);
        chk("t3_new_addr", {31'd0, ifc.arvalid, ifc.araddr}, {31'd0, 1'b1, 32'h8000_0100});
        ifc.rresp = 2'b00; ifc.rdata = 32'h1111_1111;
        repeat (2) @(negedge clock);
        chk("t3_bus", ifc.ifu_to_idu_bus, {32'h8000_0100, 32'h1111_1111});
        @(negedge clock);
        chk("t3_next_araddr", 64'(ifc.araddr), 64'h8000_0104);
        ifc.rvalid = 1'b0;

        // redirect while waiting for read data
        @(negedge clock);
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h8000_0040;
        @(negedge clock);
        ifc.redirect_valid = 1'b0;
        chk("t4_rready", 64'(ifc.rready), 64'd1);
        @(negedge clock);
        chk("t4_wait_valid", 64'(ifc.ifu_to_idu_valid), 64'd0);
        ifc.rvalid = 1'b1; ifc.rdata = 32'h2222_2222;
        @(negedge clock);
        chk("t4_drop_valid", 64'(ifc.ifu_to_idu_valid), 64'd0);
        chk("t4_new_addr", {31'd0, ifc.arvalid, ifc.araddr}, {31'd0, 1'b1, 32'h8000_0040});
        ifc.rdata = 32'h3333_3333; ifc.idu_allowin = 1'b0;
        repeat (2) @(negedge clock);
        chk("t4_bus", ifc.ifu_to_idu_bus, {32'h8000_0040, 32'h3333_3333});
        // redirect in HOLD squashes the held word even when accepted
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h8000_0200; ifc.idu_allowin = 1'b1;
        @(negedge clock);
        ifc.redirect_valid = 1'b0;
        chk("t4_hold_redir_valid", 64'(ifc.ifu_to_idu_valid), 64'd0);
        chk("t4_hold_redir_addr",  64'(ifc.araddr), 64'h8000_0200);

        // error response -> sticky fault
        ifc.rresp = 2'b10;
        repeat (2) @(negedge clock);
        chk("t5_fault", 64'(ifc.ifu_fault), 64'd1);
        chk("t5_valid", 64'(ifc.ifu_to_idu_valid), 64'd0);
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h8000_0300;
        @(negedge clock);
        ifc.redirect_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("t5_sticky", {61'd0, ifc.ifu_fault, ifc.arvalid, ifc.ifu_to_idu_valid}, {61'd0, 3'b100});
        reset = 1'b1; ifc.rresp = 2'b00;
        @(negedge clock);
        chk("t5_rst_fault", 64'(ifc.ifu_fault), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("t5_refetch", {31'd0, ifc.arvalid, ifc.araddr}, {31'd0, 1'b1, 32'h8000_0000});
        ifc.arready = 1'b0; ifc.rvalid = 1'b0; ifc.idu_allowin = 1'b0;

        // random stall stream against a memory model
        exp_pc = c_RESET_PC; slv_busy = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; accepted = 0; cycles = 0;
        while (accepted < 1000 && cycles < 30000) begin
            @(negedge clock);
            cycles++;
            if (prev_stall)
                chk("ar_stable", {31'd0, ifc.arvalid, ifc.araddr}, {31'd0, 1'b1, prev_addr});
            ifc.rvalid = 1'b0;
            if (slv_busy && ifc.rready && ($urandom_range(0, 2) != 0)) begin
                ifc.rvalid = 1'b1;
                ifc.rdata  = mem(slv_addr);
                ifc.rresp  = 2'b00;
                slv_busy   = 1'b0;
            end
            ifc.arready = 1'($urandom_range(0, 1));
            if (ifc.arvalid && ifc.arready) begin
                slv_addr = ifc.araddr;
                slv_busy = 1'b1;
            end
            prev_stall = ifc.arvalid && !ifc.arready;
            prev_addr  = ifc.araddr;
            ifc.idu_allowin = 1'($urandom_range(0, 1));
            if (ifc.ifu_to_idu_valid && ifc.idu_allowin) begin
                chk("stream_word", ifc.ifu_to_idu_bus, {exp_pc, mem(exp_pc)});
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
        end
        chk("stream_count", 64'(accepted), 64'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
